// File: rtl/cc_rsp_order_ctrl_pkg.sv
// cc_pkg: shared types and defaults for the response-order controller.
//   state_e        - controller FSM state
//   CC_BURST_LEN   - default beats per response burst
//   CC_ORDER_DEPTH - default order-queue depth (power of two)
package cc_pkg;

  localparam int CC_BURST_LEN   = 8;
  localparam int CC_ORDER_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    MISS_BURST = 2'd1,
    HIT_BURST  = 2'd2
  } state_e;

endpackage

// File: rtl/cc_order_fifo.sv
// cc_order_fifo: small synchronous FIFO holding the order of pending bursts.
//   clk, rst_n      - clock, synchronous active-low reset
//   push, push_data - write strobe / data (caller guarantees !full)
//   pop, pop_data   - read strobe (caller guarantees !empty) / head data
//   count           - registered occupancy
//   full, empty     - derived from the registered count
module cc_order_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/cc_rsp_order_ctrl.sv
// cc_rsp_order_ctrl: returns read bursts to the interconnect in request order,
// steering each burst from either the hit path (serializer) or the miss path
// (memory). rlast toward the interconnect is generated from a local beat
// counter; source rlast inputs only feed the optional checker.
//   clk, rst_n                              - clock, synchronous active-low reset
//   req_valid_i/req_hit_i/req_ready_o       - order-entry push (hit=1 -> hit path)
//   mem_rvalid_i/mem_rlast_i/mem_rready_o   - miss-path R channel
//   hit_rvalid_i/hit_rlast_i/hit_rready_o   - hit-path R channel
//   inct_rvalid_o/inct_rlast_o/inct_rready_i- R channel to interconnect
//   sel_hit_o                               - data-mux select (1 = hit data)
//   outstanding_o                           - queued entries + active burst
//   err_o                                   - sticky protocol error
// Optional: define CC_RSP_ORDER_CHK_EN to build the protocol checker; without
// it err_o is tied low.
module cc_rsp_order_ctrl
  import cc_pkg::*;
#(
  parameter int ORDER_DEPTH = CC_ORDER_DEPTH,
  parameter int BURST_LEN   = CC_BURST_LEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid_i,
  input  logic       req_hit_i,
  output logic       req_ready_o,
  input  logic       mem_rvalid_i,
  input  logic       mem_rlast_i,
  output logic       mem_rready_o,
  input  logic       hit_rvalid_i,
  input  logic       hit_rlast_i,
  output logic       hit_rready_o,
  output logic       inct_rvalid_o,
  output logic       inct_rlast_o,
  input  logic       inct_rready_i,
  output logic       sel_hit_o,
  output logic [2:0] outstanding_o,
  output logic       err_o
);

  localparam int CW = $clog2(ORDER_DEPTH) + 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  state_e        state, state_nxt;
  logic [BW-1:0] beat_cnt;
  logic          push, pop, head_hit, full, empty;
  logic [CW-1:0] count;
  logic          in_burst, hs, last_beat, last_hs, take_next;

  assign push = req_valid_i && req_ready_o;
  assign req_ready_o = !full;

  cc_order_fifo #(.DEPTH(ORDER_DEPTH), .WIDTH(1)) u_order_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (req_hit_i),
    .pop       (pop),
    .pop_data  (head_hit),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    inct_rvalid_o = 1'b0;
    mem_rready_o  = 1'b0;
    hit_rready_o  = 1'b0;
    sel_hit_o     = 1'b0;
    case (state)
      MISS_BURST: begin
        inct_rvalid_o = mem_rvalid_i;
        mem_rready_o  = inct_rready_i;
      end
      HIT_BURST: begin
        inct_rvalid_o = hit_rvalid_i;
        hit_rready_o  = inct_rready_i;
        sel_hit_o     = 1'b1;
      end
      default: ;
    endcase
  end

  assign in_burst     = (state != IDLE);
  assign hs           = in_burst && inct_rvalid_o && inct_rready_i;
  assign last_beat    = (beat_cnt == BW'(BURST_LEN - 1));
  assign last_hs      = hs && last_beat;
  assign inct_rlast_o = in_burst && last_beat;

  // A new head is taken from IDLE or straight off the last beat, so
  // back-to-back bursts have no idle bubble between them.
  assign take_next = (state == IDLE) || last_hs;
  assign pop       = take_next && !empty;

  always_comb begin
    state_nxt = state;
    if (take_next) state_nxt = empty ? IDLE : (head_hit ? HIT_BURST : MISS_BURST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (take_next)  beat_cnt <= '0;
      else if (hs)    beat_cnt <= beat_cnt + 1'b1;
    end
  end

  assign outstanding_o = 3'(count) + {2'b00, in_burst};

`ifdef CC_RSP_ORDER_CHK_EN
  logic err_q, src_rlast, rlast_bad, stray_valid;

  assign src_rlast   = (state == HIT_BURST) ? hit_rlast_i : mem_rlast_i;
  assign rlast_bad   = hs && (src_rlast != inct_rlast_o);
  // Data arriving from an unselected source with nothing queued has no
  // burst it could belong to.
  assign stray_valid = empty && ((mem_rvalid_i && state != MISS_BURST) ||
                                 (hit_rvalid_i && state != HIT_BURST));

  always_ff @(posedge clk) begin
    if (!rst_n)                        err_q <= 1'b0;
    else if (rlast_bad || stray_valid) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  logic unused_rlast;
  assign unused_rlast = mem_rlast_i ^ hit_rlast_i;
  assign err_o        = 1'b0;
`endif

endmodule
